// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// The enum order is only a state encoding; nothing depends on its values.
package mem_arb_pkg;

    localparam int BEATS   = 4;
    localparam int BEAT_W  = 2;
    localparam int WORD_W  = 32;
    localparam int MADDR_W = 8;
    localparam int IADDR_W = 6;
    localparam int BLOCK_W = BEATS * WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        D_ACC,
        I_BEAT,
        DONE_D,
        DONE_I
    } state_t;

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin grant between the data and instruction requesters.
// The last-grant flop only moves when the arbiter is allowed to hand out a grant.
module rr_arb2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic reqD_i,
    input  logic reqI_i,
    input  logic take_i,
    output logic grantD_o,
    output logic grantI_o
);

    logic lastI_q, lastI_d;

    // On contention D wins only when I held the previous grant
    always_comb begin
        grantD_o = reqD_i & (~reqI_i | lastI_q);
        grantI_o = reqI_i & ~grantD_o;
        lastI_d  = lastI_q;
        if (take_i && (grantD_o || grantI_o)) begin
            lastI_d = grantI_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lastI_q <= 1'b1;
        end else begin
            lastI_q <= lastI_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one word-wide main memory between an I-cache block refill
// port (four beats) and a D-cache single-word port.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 I_READ,
    input  logic [IADDR_W-1:0]   I_ADDRESS,
    output logic [BLOCK_W-1:0]   I_READDATA,
    output logic                 I_BUSYWAIT,
    input  logic                 D_READ,
    input  logic                 D_WRITE,
    input  logic [MADDR_W-1:0]   D_ADDRESS,
    input  logic [WORD_W-1:0]    D_WRITEDATA,
    output logic [WORD_W-1:0]    D_READDATA,
    output logic                 D_BUSYWAIT,
    output logic                 M_READ,
    output logic                 M_WRITE,
    output logic [MADDR_W-1:0]   M_ADDRESS,
    output logic [WORD_W-1:0]    M_WRITEDATA,
    input  logic [WORD_W-1:0]    M_READDATA,
    input  logic                 M_BUSYWAIT
);

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 gap_q, gap_d;
    logic [IADDR_W-1:0]   iAddr_q, iAddr_d;
    logic [MADDR_W-1:0]   dAddr_q, dAddr_d;
    logic [WORD_W-1:0]    dWdata_q, dWdata_d;
    logic                 dRead_q, dRead_d;
    logic                 dWrite_q, dWrite_d;
    logic [3*WORD_W-1:0]  iBuf_q, iBuf_d;
    logic [BLOCK_W-1:0]   iData_q, iData_d;
    logic [WORD_W-1:0]    dData_q, dData_d;

    logic dPend, iPend, grantD, grantI, memDone, lastBeat;

    assign dPend    = D_READ | D_WRITE;
    assign iPend    = I_READ;
    assign memDone  = (M_READ | M_WRITE) & ~M_BUSYWAIT;
    assign lastBeat = (beat_q == BEAT_W'(BEATS - 1));

    rr_arb2 u_arb (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .reqD_i   (dPend),
        .reqI_i   (iPend),
        .take_i   (state_q == IDLE),
        .grantD_o (grantD),
        .grantI_o (grantI)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grantD) state_d = D_ACC;
                     else if (grantI) state_d = I_BEAT;
            D_ACC:   if (memDone) state_d = DONE_D;
            I_BEAT:  if (memDone && lastBeat) state_d = DONE_I;
            DONE_D,
            DONE_I:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes drop during the I gap cycle and in both DONE states
    always_comb begin
        M_READ      = 1'b0;
        M_WRITE     = 1'b0;
        M_ADDRESS   = '0;
        M_WRITEDATA = '0;
        case (state_q)
            D_ACC: begin
                M_READ      = dRead_q;
                M_WRITE     = dWrite_q;
                M_ADDRESS   = dAddr_q;
                M_WRITEDATA = dWdata_q;
            end
            I_BEAT: begin
                M_READ    = ~gap_q;
                M_ADDRESS = {iAddr_q, beat_q};
            end
            default: ;
        endcase
        D_BUSYWAIT = dPend & (state_q != DONE_D);
        I_BUSYWAIT = iPend & (state_q != DONE_I);
    end

    // Refill words collect in iBuf; the visible block only changes on the last beat
    always_comb begin
        beat_d   = beat_q;
        gap_d    = gap_q;
        iAddr_d  = iAddr_q;
        dAddr_d  = dAddr_q;
        dWdata_d = dWdata_q;
        dRead_d  = dRead_q;
        dWrite_d = dWrite_q;
        iBuf_d   = iBuf_q;
        iData_d  = iData_q;
        dData_d  = dData_q;
        case (state_q)
            IDLE: begin
                if (grantD) begin
                    dAddr_d  = D_ADDRESS;
                    dWdata_d = D_WRITEDATA;
                    dWrite_d = D_WRITE;
                    dRead_d  = D_READ & ~D_WRITE;
                end else if (grantI) begin
                    iAddr_d = I_ADDRESS;
                    beat_d  = '0;
                    gap_d   = 1'b0;
                end
            end
            D_ACC: begin
                if (memDone && dRead_q) dData_d = M_READDATA;
            end
            I_BEAT: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (memDone) begin
                    if (lastBeat) begin
                        iData_d = {M_READDATA, iBuf_q};
                        beat_d  = '0;
                    end else begin
                        case (beat_q)
                            2'd0:    iBuf_d[WORD_W-1:0]          = M_READDATA;
                            2'd1:    iBuf_d[2*WORD_W-1:WORD_W]   = M_READDATA;
                            default: iBuf_d[3*WORD_W-1:2*WORD_W] = M_READDATA;
                        endcase
                        beat_d = beat_q + 2'd1;
                        gap_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            beat_q   <= '0;
            gap_q    <= 1'b0;
            iAddr_q  <= '0;
            dAddr_q  <= '0;
            dWdata_q <= '0;
            dRead_q  <= 1'b0;
            dWrite_q <= 1'b0;
            iBuf_q   <= '0;
            iData_q  <= '0;
            dData_q  <= '0;
        end else begin
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            iAddr_q  <= iAddr_d;
            dAddr_q  <= dAddr_d;
            dWdata_q <= dWdata_d;
            dRead_q  <= dRead_d;
            dWrite_q <= dWrite_d;
            iBuf_q   <= iBuf_d;
            iData_q  <= iData_d;
            dData_q  <= dData_d;
        end
    end

    assign I_READDATA = iData_q;
    assign D_READDATA = dData_q;

endmodule
